// File: rtl/servant_irq_pkg.sv
// Shared constants and helpers for the servant external interrupt controller.
package servant_irq_pkg;

  localparam int ID_W = 5;

  localparam logic [1:0] ADR_PENDING = 2'd0;
  localparam logic [1:0] ADR_ENABLE  = 2'd1;
  localparam logic [1:0] ADR_CLAIM   = 2'd2;
  localparam logic [1:0] ADR_COUNT   = 2'd3;

  // Lowest set bit index plus one; zero when the vector is empty.
  // Bit 31 is never populated because a 5-bit id cannot encode 32.
  function automatic logic [ID_W-1:0] prio_id(input logic [31:0] vec);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 30; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/servant_irq_sync.sv
// Multi-flop synchroniser bringing asynchronous interrupt lines into wb_clk.
module servant_irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/servant_irq_ctrl.sv
// N-channel edge/level interrupt controller with a Wishbone register file
// exposing PENDING, ENABLE, CLAIM and COUNT.
module servant_irq_ctrl
  import servant_irq_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter logic [31:0] EDGE_MASK   = 32'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [1:0]         i_wb_adr,
  input  logic [31:0]        i_wb_dat,
  input  logic               i_wb_we,
  input  logic               i_wb_cyc,
  output logic [31:0]        o_wb_rdt,
  output logic               o_wb_ack,
  output logic               o_ext_irq,
  output logic [ID_W-1:0]    o_irq_id
);

  localparam logic [NUM_IRQ-1:0] EDGE = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] s_irq, prev_irq, pending, enable, active;
  logic [NUM_IRQ-1:0] w1c, claim_clr, pending_nxt;
  logic [31:0]        count, rd_mux;
  logic [ID_W-1:0]    irq_id;
  logic               acc, rd_acc, wr_acc;
  logic               unused_dat;

  servant_irq_sync #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .d       (i_irq),
    .q       (s_irq)
  );

  // An access is the cycle on which the ack gets registered.
  assign acc    = i_wb_cyc & ~o_wb_ack;
  assign rd_acc = acc & ~i_wb_we;
  assign wr_acc = acc & i_wb_we;

  assign active     = pending & enable;
  assign irq_id     = prio_id(32'(active));
  assign o_irq_id   = irq_id;
  assign unused_dat = ^i_wb_dat;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w1c       = '0;
    claim_clr = '0;
    if (wr_acc && i_wb_adr == ADR_PENDING) w1c = i_wb_dat[NUM_IRQ-1:0] & EDGE;
    if (rd_acc && i_wb_adr == ADR_CLAIM) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (irq_id == ID_W'(i + 1)) claim_clr[i] = EDGE[i];
      end
    end
    // A fresh edge wins over a same-cycle claim or W1C.
    pending_nxt = (EDGE & ((s_irq & ~prev_irq) | (pending & ~(w1c | claim_clr))))
                | (~EDGE & s_irq);
  end

  always_comb begin
    rd_mux = '0;
    case (i_wb_adr)
      ADR_PENDING: rd_mux = 32'(pending);
      ADR_ENABLE:  rd_mux = 32'(enable);
      ADR_CLAIM:   rd_mux = 32'(irq_id);
      default:     rd_mux = count;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      prev_irq  <= '0;
      pending   <= '0;
      enable    <= '0;
      count     <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_rdt  <= '0;
      o_ext_irq <= 1'b0;
    end else begin
      prev_irq  <= s_irq;
      pending   <= pending_nxt;
      o_wb_ack  <= acc;
      o_ext_irq <= |active;
      if (acc) o_wb_rdt <= rd_mux;
      if (wr_acc && i_wb_adr == ADR_ENABLE) enable <= i_wb_dat[NUM_IRQ-1:0];
      // Counts rising edges of the registered o_ext_irq; a write wins over an increment.
      if (wr_acc && i_wb_adr == ADR_COUNT) count <= '0;
      else if (|active && !o_ext_irq)      count <= count + 32'd1;
    end
  end

endmodule

// File: tb/tb_servant_irq_ctrl.sv
// Directed bench for servant_irq_ctrl: register reads go through a scoreboard queue.
module tb_servant_irq_ctrl;
  import servant_irq_pkg::*;

  localparam int NUM_IRQ = 8;
  localparam int SYNC    = 2;

  logic               wb_clk = 1'b0;
  logic               wb_rst_n = 1'b0;
  logic [NUM_IRQ-1:0] i_irq = '0;
  logic [1:0]         i_wb_adr = '0;
  logic [31:0]        i_wb_dat = '0;
  logic               i_wb_we = 1'b0;
  logic               i_wb_cyc = 1'b0;
  logic [31:0]        o_wb_rdt;
  logic               o_wb_ack;
  logic               o_ext_irq;
  logic [ID_W-1:0]    o_irq_id;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  servant_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .EDGE_MASK(32'h0F), .SYNC_STAGES(SYNC)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_irq    (i_irq),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_ext_irq(o_ext_irq),
    .o_irq_id (o_irq_id)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the ack edge.
  task automatic bus(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                     output logic [31:0] rdt);
    bit got = 0;
    i_wb_adr = adr;
    i_wb_we  = we;
    i_wb_dat = dat;
    i_wb_cyc = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick(1);
      if (o_wb_ack) got = 1;
    end
    rdt      = o_wb_rdt;
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
    logic [31:0] unused_rdt;
    bus(adr, 1'b1, dat, unused_rdt);
    tick(1);
  endtask

  task automatic rd(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] rdt;
    exp_q.push_back(exp);
    bus(adr, 1'b0, 32'd0, rdt);
    check(tag, rdt, exp_q.pop_front());
    tick(1);
  endtask

  task automatic pulse(input int ch);
    i_irq[ch] = 1'b1;
    tick(1);
    i_irq[ch] = 1'b0;
  endtask

  initial begin
    #23 wb_rst_n = 1'b1;
    @(posedge wb_clk);
    #1;

    // Reset state
    check("rst_ext_irq", 32'(o_ext_irq), 32'd0);
    check("rst_irq_id", 32'(o_irq_id), 32'd0);
    rd("rst_pending", ADR_PENDING, 32'd0);
    rd("rst_enable", ADR_ENABLE, 32'd0);
    rd("rst_claim", ADR_CLAIM, 32'd0);
    rd("rst_count", ADR_COUNT, 32'd0);

    // Edge channel 2: exact latency, claim, count
    wr(ADR_ENABLE, 32'hFFFF_FFFF);
    rd("enable_upper_zero", ADR_ENABLE, 32'h0000_00FF);
    pulse(2);
    tick(SYNC);
    check("lat_ext_early", 32'(o_ext_irq), 32'd0);
    tick(1);
    check("lat_ext_on_time", 32'(o_ext_irq), 32'd1);
    check("id_ch2", 32'(o_irq_id), 32'd3);
    rd("pending_ch2", ADR_PENDING, 32'h04);
    rd("claim_ch2", ADR_CLAIM, 32'd3);
    rd("pending_after_claim", ADR_PENDING, 32'h00);
    check("ext_after_claim", 32'(o_ext_irq), 32'd0);
    rd("count_one", ADR_COUNT, 32'd1);

    // Level ch5 with edge ch1
    i_irq[5] = 1'b1;
    i_irq[1] = 1'b1;
    tick(6);
    rd("claim_edge_ch1", ADR_CLAIM, 32'd2);
    rd("claim_level_ch5", ADR_CLAIM, 32'd6);
    rd("pending_level_kept", ADR_PENDING, 32'h20);
    i_irq[5] = 1'b0;
    i_irq[1] = 1'b0;
    tick(6);
    check("ext_level_gone", 32'(o_ext_irq), 32'd0);
    rd("pending_level_gone", ADR_PENDING, 32'h00);
    rd("count_two", ADR_COUNT, 32'd2);

    // Masked pending on ch0
    wr(ADR_ENABLE, 32'h0);
    pulse(0);
    tick(6);
    check("masked_ext", 32'(o_ext_irq), 32'd0);
    check("masked_id", 32'(o_irq_id), 32'd0);
    rd("masked_pending", ADR_PENDING, 32'h01);
    begin
      logic [31:0] unused_rdt;
      bus(ADR_ENABLE, 1'b1, 32'h01, unused_rdt);
    end
    check("unmask_ext_not_yet", 32'(o_ext_irq), 32'd0);
    tick(1);
    check("unmask_ext_rises", 32'(o_ext_irq), 32'd1);
    wr(ADR_PENDING, 32'h01);
    check("w1c_ext_falls", 32'(o_ext_irq), 32'd0);

    // Edge on ch3 coinciding with its claim
    wr(ADR_ENABLE, 32'hFF);
    pulse(3);
    tick(6);
    check("ch3_ext", 32'(o_ext_irq), 32'd1);
    i_irq[3] = 1'b1;
    tick(2);
    rd("claim_race_ch3", ADR_CLAIM, 32'd4);
    check("race_ext_held", 32'(o_ext_irq), 32'd1);
    rd("race_pending_kept", ADR_PENDING, 32'h08);
    i_irq[3] = 1'b0;
    wr(ADR_PENDING, 32'h08);
    tick(1);
    check("race_cleared_ext", 32'(o_ext_irq), 32'd0);
    rd("count_four", ADR_COUNT, 32'd4);

    // COUNT wrap and write-to-clear
    force dut.count = 32'hFFFF_FFFF;
    tick(1);
    release dut.count;
    rd("count_preload", ADR_COUNT, 32'hFFFF_FFFF);
    pulse(0);
    tick(6);
    rd("count_wrap", ADR_COUNT, 32'h0);
    wr(ADR_PENDING, 32'h01);
    tick(1);
    pulse(1);
    tick(6);
    rd("count_after_wrap", ADR_COUNT, 32'd1);
    wr(ADR_COUNT, 32'h1234);
    rd("count_write_clear", ADR_COUNT, 32'd0);

    // Reset in the middle of an access
    i_wb_adr = ADR_PENDING;
    i_wb_we  = 1'b0;
    i_wb_cyc = 1'b1;
    tick(1);
    check("midacc_ack_up", 32'(o_wb_ack), 32'd1);
    wb_rst_n = 1'b0;
    #1;
    check("midacc_ack_drop", 32'(o_wb_ack), 32'd0);
    check("midacc_ext_drop", 32'(o_ext_irq), 32'd0);
    check("midacc_id_drop", 32'(o_irq_id), 32'd0);
    i_wb_cyc = 1'b0;
    tick(1);
    wb_rst_n = 1'b1;
    tick(1);
    rd("post_rst_pending", ADR_PENDING, 32'd0);
    rd("post_rst_enable", ADR_ENABLE, 32'd0);
    rd("post_rst_claim", ADR_CLAIM, 32'd0);
    rd("post_rst_count", ADR_COUNT, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
